// File: rtl/clint_timer_ctrl.sv
// clint_timer_ctrl
// Machine timer and software interrupt controller. It owns the 64-bit mtime
// counter, mtimecmp and msip, and exposes them through a 32-bit register-bus
// slave that handles one transaction at a time. It also drives the level
// timer and software interrupt lines.
//
// Ports:
//   CLK        core clock, rising edge
//   RST        synchronous active-high reset
//   req        bus request, held by the master until ack
//   wen        1 = write, 0 = read
//   addr       byte offset; addr[4:2] selects the register
//   wdata      write data
//   rdata      read data, valid while ack, 0 otherwise
//   ack        one-cycle completion pulse
//   err        set with ack for offsets 0x18/0x1C
//   mtime      current timer value (registered)
//   timer_int  registered (mtime >= mtimecmp)
//   soft_int   registered copy of msip
//
// Register map (addr[4:2]): 0 MTIME_LO, 1 MTIME_HI, 2 MTIMECMP_LO,
// 3 MTIMECMP_HI, 4 MSIP (bit 0), 5 CTRL (bit 0 = count enable), 6/7 unmapped.
module clint_timer_ctrl #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req,
    input  logic        wen,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic [63:0] mtime,
    output logic        timer_int,
    output logic        soft_int
);

    localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

    typedef enum logic {S_IDLE, S_RESP} state_e;

    state_e      state_q;
    logic        wen_q;
    logic [2:0]  idx_q;
    logic [31:0] wdata_q;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q;
    logic [31:0] shadow_q;
    logic        msip_q;
    logic        en_q;
    logic [15:0] presc_q, presc_d;
    logic [31:0] rdata_q;
    logic        ack_q;
    logic        err_q;
    logic        tint_q;
    logic        sint_q;

    logic        wr_lo;
    logic        wr_hi;
    logic        unmapped;
    logic [31:0] rd_val;

    // Byte-lane bits of the offset carry no meaning.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[1:0];

    // Writes commit on the edge that leaves RESP.
    assign wr_lo    = (state_q == S_RESP) && wen_q && (idx_q == 3'd0);
    assign wr_hi    = (state_q == S_RESP) && wen_q && (idx_q == 3'd1);
    assign unmapped = idx_q[2] && idx_q[1];

    // A software write to either mtime half wins over a pending increment
    // and restarts the prescale period.
    always_comb begin
        mtime_d = mtime_q;
        presc_d = presc_q;
        if (wr_lo) begin
            mtime_d[31:0] = wdata_q;
            presc_d       = 16'd0;
        end else if (wr_hi) begin
            mtime_d[63:32] = wdata_q;
            presc_d        = 16'd0;
        end else if (en_q) begin
            if (presc_q == PS_LAST) begin
                presc_d = 16'd0;
                mtime_d = mtime_q + 64'd1;
            end else begin
                presc_d = presc_q + 16'd1;
            end
        end
    end

    // MTIME_HI returns the half captured by the last MTIME_LO read so a
    // LO-then-HI sequence is never torn by a carry in between.
    always_comb begin
        rd_val = 32'd0;
        case (idx_q)
            3'd0:    rd_val = mtime_q[31:0];
            3'd1:    rd_val = shadow_q;
            3'd2:    rd_val = mtimecmp_q[31:0];
            3'd3:    rd_val = mtimecmp_q[63:32];
            3'd4:    rd_val = {31'd0, msip_q};
            3'd5:    rd_val = {31'd0, en_q};
            default: rd_val = 32'd0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            wen_q      <= 1'b0;
            idx_q      <= 3'd0;
            wdata_q    <= 32'd0;
            mtime_q    <= 64'd0;
            mtimecmp_q <= '1;
            shadow_q   <= 32'd0;
            msip_q     <= 1'b0;
            en_q       <= 1'b1;
            presc_q    <= 16'd0;
            rdata_q    <= 32'd0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            tint_q     <= 1'b0;
            sint_q     <= 1'b0;
        end else begin
            mtime_q <= mtime_d;
            presc_q <= presc_d;
            tint_q  <= (mtime_q >= mtimecmp_q);
            sint_q  <= msip_q;
            case (state_q)
                S_IDLE: begin
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= 32'd0;
                    if (req) begin
                        wen_q   <= wen;
                        idx_q   <= addr[4:2];
                        wdata_q <= wdata;
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    ack_q   <= 1'b1;
                    err_q   <= unmapped;
                    rdata_q <= wen_q ? 32'd0 : rd_val;
                    if (!wen_q && (idx_q == 3'd0)) begin
                        shadow_q <= mtime_q[63:32];
                    end
                    if (wen_q) begin
                        case (idx_q)
                            3'd2:    mtimecmp_q[31:0]  <= wdata_q;
                            3'd3:    mtimecmp_q[63:32] <= wdata_q;
                            3'd4:    msip_q            <= wdata_q[0];
                            3'd5:    en_q              <= wdata_q[0];
                            default: ;
                        endcase
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rdata     = rdata_q;
    assign ack       = ack_q;
    assign err       = err_q;
    assign mtime     = mtime_q;
    assign timer_int = tint_q;
    assign soft_int  = sint_q;

endmodule

// File: tb/tb_clint_timer_ctrl.sv
// Bench for clint_timer_ctrl: two instances (PRESCALE 1 and 4) share one bus
// stimulus; a behavioural model predicts every output of both on each cycle.
module tb_clint_timer_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req = 1'b0;
    logic        wen = 1'b0;
    logic [4:0]  addr = 5'd0;
    logic [31:0] wdata = 32'd0;

    logic [31:0] rdata1, rdata4;
    logic        ack1, ack4, err1, err4, tint1, tint4, sint1, sint4;
    logic [63:0] mtime1, mtime4;

    int n_chk = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    clint_timer_ctrl #(.PRESCALE(1)) dut1 (
        .CLK(CLK), .RST(RST), .req(req), .wen(wen), .addr(addr), .wdata(wdata),
        .rdata(rdata1), .ack(ack1), .err(err1), .mtime(mtime1),
        .timer_int(tint1), .soft_int(sint1)
    );

    clint_timer_ctrl #(.PRESCALE(4)) dut4 (
        .CLK(CLK), .RST(RST), .req(req), .wen(wen), .addr(addr), .wdata(wdata),
        .rdata(rdata4), .ack(ack4), .err(err4), .mtime(mtime4),
        .timer_int(tint4), .soft_int(sint4)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mtime is held as an anchor value plus a count of enabled cycles since
    // the anchor; the visible value is anchor + cycles / N.
    logic [63:0] m_base [2];
    logic [63:0] m_run  [2];
    logic [63:0] m_cmp  [2];
    logic        m_msip [2];
    logic        m_en   [2];
    logic [31:0] m_shad [2];
    logic [31:0] m_rd   [2];
    logic        m_ack  [2];
    logic        m_err  [2];
    logic        m_ti   [2];
    logic        m_si   [2];
    logic        pend = 1'b0;
    logic        p_wen;
    logic [2:0]  p_idx;
    logic [31:0] p_wd;
    logic        seen_rst = 1'b0;

    function automatic logic [63:0] np(input int i);
        return (i == 0) ? 64'd1 : 64'd4;
    endfunction

    function automatic logic [63:0] mmt(input int i);
        return m_base[i] + m_run[i] / np(i);
    endfunction

    always @(posedge CLK) begin
        logic [63:0] cur;
        logic        en_old, mwr, nt, ns;
        if (RST) begin
            for (int i = 0; i < 2; i++) begin
                m_base[i] = 64'd0; m_run[i] = 64'd0; m_cmp[i] = '1;
                m_msip[i] = 1'b0; m_en[i] = 1'b1; m_shad[i] = 32'd0;
                m_rd[i] = 32'd0; m_ack[i] = 1'b0; m_err[i] = 1'b0;
                m_ti[i] = 1'b0; m_si[i] = 1'b0;
            end
            pend     = 1'b0;
            seen_rst = 1'b1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                cur    = mmt(i);
                en_old = m_en[i];
                mwr    = 1'b0;
                nt     = (cur >= m_cmp[i]);
                ns     = m_msip[i];
                m_rd[i]  = 32'd0;
                m_ack[i] = pend;
                m_err[i] = pend && (p_idx >= 3'd6);
                if (pend && !p_wen) begin
                    case (p_idx)
                        3'd0: begin m_rd[i] = cur[31:0]; m_shad[i] = cur[63:32]; end
                        3'd1: m_rd[i] = m_shad[i];
                        3'd2: m_rd[i] = m_cmp[i][31:0];
                        3'd3: m_rd[i] = m_cmp[i][63:32];
                        3'd4: m_rd[i] = {31'd0, m_msip[i]};
                        3'd5: m_rd[i] = {31'd0, m_en[i]};
                        default: m_rd[i] = 32'd0;
                    endcase
                end else if (pend && p_wen) begin
                    case (p_idx)
                        3'd0: begin m_base[i] = {cur[63:32], p_wd}; m_run[i] = 64'd0; mwr = 1'b1; end
                        3'd1: begin m_base[i] = {p_wd, cur[31:0]}; m_run[i] = 64'd0; mwr = 1'b1; end
                        3'd2: m_cmp[i][31:0]  = p_wd;
                        3'd3: m_cmp[i][63:32] = p_wd;
                        3'd4: m_msip[i] = p_wd[0];
                        3'd5: m_en[i]   = p_wd[0];
                        default: ;
                    endcase
                end
                if (!mwr && en_old) m_run[i] = m_run[i] + 64'd1;
                m_ti[i] = nt;
                m_si[i] = ns;
            end
            if (pend) begin
                pend = 1'b0;
            end else if (req) begin
                pend  = 1'b1;
                p_wen = wen;
                p_idx = addr[4:2];
                p_wd  = wdata;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge CLK) begin
        if (seen_rst) begin
            chk("mtime_p1", mtime1, mmt(0));
            chk("ack_p1", {63'd0, ack1}, {63'd0, m_ack[0]});
            chk("rdata_p1", {32'd0, rdata1}, {32'd0, m_rd[0]});
            chk("err_p1", {63'd0, err1}, {63'd0, m_err[0]});
            chk("tint_p1", {63'd0, tint1}, {63'd0, m_ti[0]});
            chk("sint_p1", {63'd0, sint1}, {63'd0, m_si[0]});
            chk("mtime_p4", mtime4, mmt(1));
            chk("ack_p4", {63'd0, ack4}, {63'd0, m_ack[1]});
            chk("rdata_p4", {32'd0, rdata4}, {32'd0, m_rd[1]});
            chk("err_p4", {63'd0, err4}, {63'd0, m_err[1]});
            chk("tint_p4", {63'd0, tint4}, {63'd0, m_ti[1]});
            chk("sint_p4", {63'd0, sint4}, {63'd0, m_si[1]});
        end
    end

    // One bus transaction; returns on the negedge where ack is visible.
    task automatic bus(input logic w, input logic [4:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic e);
        int k;
        @(negedge CLK);
        req = 1'b1; wen = w; addr = a; wdata = d;
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (ack1 !== 1'b1 && k < 4);
        chk("bus_ack_latency", 64'(k), 64'd2);
        rd  = rdata1;
        e   = err1;
        req = 1'b0;
    endtask

    initial begin
        logic [31:0] rd, lo, hi;
        logic        e;
        int          k;

        // Reset, then free-run 10 cycles.
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (10) @(posedge CLK);
        #1;
        chk("idle_mtime_p1", mtime1, 64'd10);
        chk("idle_mtime_p4", mtime4, 64'd2);
        chk("idle_ack", {63'd0, ack1}, 64'd0);
        chk("idle_tint", {63'd0, tint1}, 64'd0);

        // Timer compare at 20.
        @(negedge CLK); RST = 1'b1;
        @(negedge CLK); RST = 1'b0;
        bus(1'b1, 5'h0C, 32'd0, rd, e);
        bus(1'b1, 5'h08, 32'd20, rd, e);
        k = 0;
        while (mtime1 != 64'd20 && k < 100) begin
            @(negedge CLK);
            k++;
        end
        chk("cmp_reach_timeout", {63'd0, k >= 100}, 64'd0);
        chk("tint_at_20", {63'd0, tint1}, 64'd0);
        @(negedge CLK);
        chk("tint_after_20", {63'd0, tint1}, 64'd1);
        bus(1'b1, 5'h08, 32'hFFFF_FFFF, rd, e);
        chk("tint_at_cmp_ack", {63'd0, tint1}, 64'd1);
        @(negedge CLK);
        chk("tint_after_cmp_ack", {63'd0, tint1}, 64'd0);

        // Atomic 64-bit read across a carry.
        bus(1'b1, 5'h04, 32'd0, rd, e);
        bus(1'b1, 5'h00, 32'hFFFF_FFFF, rd, e);
        bus(1'b0, 5'h00, 32'd0, lo, e);
        repeat (3) @(negedge CLK);
        bus(1'b0, 5'h04, 32'd0, hi, e);
        chk("atomic_lo", {32'd0, lo}, 64'd1);
        chk("atomic_hi", {32'd0, hi}, 64'd1);

        // Disable, load 1000, hold, then resume.
        bus(1'b1, 5'h14, 32'd0, rd, e);
        bus(1'b1, 5'h04, 32'd0, rd, e);
        bus(1'b1, 5'h00, 32'd1000, rd, e);
        repeat (50) @(negedge CLK);
        chk("hold_p1", mtime1, 64'd1000);
        chk("hold_p4", mtime4, 64'd1000);
        bus(1'b0, 5'h14, 32'd0, rd, e);
        chk("ctrl_read0", {32'd0, rd}, 64'd0);
        bus(1'b1, 5'h14, 32'd1, rd, e);
        chk("resume0_p1", mtime1, 64'd1000);
        chk("resume0_p4", mtime4, 64'd1000);
        for (int j = 1; j <= 8; j++) begin
            @(negedge CLK);
            chk("resume_p1", mtime1, 64'd1000 + 64'(j));
            chk("resume_p4", mtime4, 64'd1000 + 64'(j / 4));
        end

        // MSIP and unmapped offsets.
        bus(1'b1, 5'h10, 32'hFFFF_FFFF, rd, e);
        chk("sint_at_ack", {63'd0, sint1}, 64'd0);
        @(negedge CLK);
        chk("sint_t2", {63'd0, sint1}, 64'd1);
        bus(1'b0, 5'h10, 32'd0, rd, e);
        chk("msip_read", {32'd0, rd}, 64'd1);
        bus(1'b0, 5'h18, 32'd0, rd, e);
        chk("unmapped_rdata", {32'd0, rd}, 64'd0);
        chk("unmapped_rd_err", {63'd0, e}, 64'd1);
        bus(1'b1, 5'h1C, 32'h5, rd, e);
        chk("unmapped_wr_err", {63'd0, e}, 64'd1);

        // MTIME_LO write against a scheduled increment.
        bus(1'b1, 5'h00, 32'h1234_5678, rd, e);
        chk("lo_write_exact_p1", {32'd0, mtime1[31:0]}, 64'h1234_5678);
        chk("lo_write_exact_p4", {32'd0, mtime4[31:0]}, 64'h1234_5678);
        @(negedge CLK);
        chk("lo_write_next_p1", {32'd0, mtime1[31:0]}, 64'h1234_5679);

        // Reset while in RESP.
        @(negedge CLK);
        req = 1'b1; wen = 1'b1; addr = 5'h00; wdata = 32'h0000_0ABC;
        @(negedge CLK);
        RST = 1'b1; req = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        chk("rst_resp_mtime", mtime1, 64'd0);
        chk("rst_resp_ack", {63'd0, ack1}, 64'd0);
        chk("rst_resp_rdata", {32'd0, rdata1}, 64'd0);
        chk("rst_resp_err", {63'd0, err1}, 64'd0);
        chk("rst_resp_tint", {63'd0, tint1}, 64'd0);
        chk("rst_resp_sint", {63'd0, sint1}, 64'd0);
        for (int j = 1; j <= 4; j++) begin
            @(negedge CLK);
            chk("post_rst_ack", {63'd0, ack1}, 64'd0);
            chk("post_rst_mtime", mtime1, 64'(j));
        end

        // Randomized traffic.
        for (int n = 0; n < 250; n++) begin
            logic [2:0]  idx;
            logic [31:0] d;
            idx = 3'($urandom_range(0, 7));
            d   = $urandom;
            case (idx)
                3'd1, 3'd3: if ($urandom_range(0, 3) != 0) d = 32'd0;
                3'd2:       d = mtime1[31:0] + 32'($urandom_range(0, 40)) - 32'd20;
                3'd5:       if ($urandom_range(0, 3) != 0) d = 32'd1;
                default: ;
            endcase
            bus(1'($urandom_range(0, 1)), {idx, 2'($urandom)}, d, rd, e);
            repeat ($urandom_range(0, 5)) @(negedge CLK);
            if ($urandom_range(0, 59) == 0) begin
                @(negedge CLK); RST = 1'b1;
                @(negedge CLK); RST = 1'b0;
            end
        end

        repeat (5) @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #900000;
        n_err++;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/clint_timer_ctrl.md
# clint_timer_ctrl

Machine-level timer and software-interrupt controller that owns the 64-bit `mtime` counter consumed by the privileged-ISA block. It also owns `mtimecmp` and `msip`, exposes them to software through a 32-bit single-outstanding register-bus slave, and drives the timer and software interrupt lines. These lines feed the core interrupt interface. The block is instantiated beside the priv wrapper; its `mtime` output connects directly to the priv wrapper's `mtime` input.

## Interface
- `PRESCALE`, default 1: number of CLK cycles per `mtime` increment; legal range 1..65535.
- `CLK`  in  1  core clock; all state updates on its rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `req`  in  1  bus request; held by master until `ack`.
- `wen`  in  1  1 = write, 0 = read; valid with `req`.
- `addr`  in  5  byte offset; bits [1:0] ignored.
- `wdata`  in  32  write data; valid with `req` and `wen`.
- `rdata`  out  32  read data; valid only while `ack`.
- `ack`  out  1  one-cycle completion pulse.
- `err`  out  1  asserted with `ack` for an unmapped offset.
- `mtime`  out  64  current timer value, registered.
- `timer_int`  out  1  machine timer interrupt, level.
- `soft_int`  out  1  machine software interrupt, level.

## Operation
Register map by `addr[4:2]`:
- 0: MTIME_LO
- 1: MTIME_HI
- 2: MTIMECMP_LO
- 3: MTIMECMP_HI
- 4: MSIP, bit 0 only; other bits read 0, writes ignored.
- 5: CTRL, bit 0 = count enable; other bits read 0.
- 6, 7: unmapped. Reads return 0 with `err`=1; writes have no effect and return `err`=1.

Bus FSM:
- IDLE: if `req`, latch `wen`, `addr` and `wdata`, then go to RESP.
- RESP: drive `ack`=1 (with `err` as above), then return to IDLE.
- A `req` seen in RESP is ignored. A `req` still high in the IDLE cycle after `ack` starts a new transaction, so the master must drop `req` the cycle after `ack`.

Atomic 64-bit read:
- A read of MTIME_LO returns `mtime[31:0]` and, on the same edge, copies `mtime[63:32]` into a shadow register.
- A read of MTIME_HI returns the shadow, not the live value.
- Writes to either MTIME half do not touch the shadow.

Counting:
- While CTRL.enable=1, the prescale counter runs 0..PRESCALE-1. At terminal count it wraps to 0 and `mtime` increments by 1.
- `mtime` wraps from 2^64-1 to 0.
- While enable=0, both the prescale counter and `mtime` hold.

Software writes:
- A write to an MTIME half replaces only that half.
- Write beats increment: an increment scheduled for the same edge is dropped, and the prescale counter clears to 0.
- MTIMECMP half writes replace only that half and have no side effects.

Interrupts:
- `timer_int` is registered: next value = (`mtime` >= `mtimecmp`), unsigned 64-bit compare on the current register values.
- `soft_int` is the registered copy of MSIP bit 0.

Reset values:
- `mtime` = 0, `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF, MSIP = 0, CTRL.enable = 1.
- shadow = 0, prescale counter = 0, FSM = IDLE.
- `rdata`, `ack`, `err`, `timer_int` and `soft_int` all = 0.

## Timing
- Request sampled in IDLE at edge t. The write takes effect and `ack` rises at edge t+1. `ack` falls at t+2.
- Read data is captured at edge t+1 from values present before that edge. It is valid while `ack`=1 and is 0 otherwise.
- Throughput: one transaction every 2 cycles.
- `timer_int` rises 1 cycle after `mtime` first satisfies `mtime` >= `mtimecmp`.
- `timer_int` falls 1 cycle after the edge at which a `mtimecmp` write makes the compare false.
- `soft_int` follows a MSIP write by 1 cycle after `ack`, i.e. at edge t+2.
- With PRESCALE=N and enable=1 from reset, `mtime` = k at edge k·N.
- `RST` asserted mid-transaction aborts it: no `ack` is issued, all state returns to reset values on that edge, and a write in flight is not committed.
- `RST` has priority over every other event on the same edge.

## Test plan
- Reset then idle, PRESCALE=1: `mtime` = 10 after 10 cycles. `timer_int`=0, `soft_int`=0, `ack`=0 throughout.
- Write MTIMECMP_HI=0 then MTIMECMP_LO=20, PRESCALE=1: `timer_int` rises exactly one cycle after `mtime` reaches 20. Writing MTIMECMP_LO=0xFFFF_FFFF then deasserts it one cycle after that write's `ack`.
- Write MTIME_LO=0xFFFF_FFFF and MTIME_HI=0 with enable=1, then read MTIME_LO followed by MTIME_HI: the HI read returns the value shadowed at the LO read (0 or 1), consistent with the returned LO and never torn.
- Write CTRL=0: `mtime` holds for 50 cycles. Write CTRL=1: counting resumes with PRESCALE=4 stepping every 4th cycle.
- Write MSIP=0xFFFF_FFFF: `soft_int`=1 at t+2 and MSIP reads back 0x1. Read offset 0x18: `rdata`=0 with `err`=1 and `ack`=1.
- Write MTIME_LO on the same edge as a scheduled increment: `mtime[31:0]` equals `wdata` exactly. Assert `RST` during RESP: `ack` never pulses and all outputs equal their reset values on the next cycle.
